// File: rtl/vanilla_sb_clear_pkg.sv
// rtl/vanilla_sb_clear_pkg.sv - shared types and rr-flag encoding for the sb clear arbiter
package vanilla_sb_clear_pkg;

  localparam int sb_clear_reg_addr_width_gp = 5;

  typedef struct packed {
    logic       is_float;
    logic [4:0] id;
  } sb_clear_rsp_s;

  localparam logic sb_clear_src_fifo_gp = 1'b0;
  localparam logic sb_clear_src_unit_gp = 1'b1;

endpackage

// File: rtl/vanilla_sb_clear_arbiter_if.sv
// rtl/vanilla_sb_clear_arbiter_if.sv - event/clear bundle between core-side sources and the sb clear arbiter
interface vanilla_sb_clear_arbiter_if #(
  parameter int reg_addr_width_p = 5,
  parameter int count_width_lp   = 5
);
  logic                        issue_remote_ld_i;
  logic                        rsp_v_i;
  logic                        rsp_float_i;
  logic [reg_addr_width_p-1:0] rsp_id_i;
  logic                        rsp_ready_o;
  logic                        idiv_v_i;
  logic [reg_addr_width_p-1:0] idiv_id_i;
  logic                        idiv_yumi_o;
  logic                        fdiv_v_i;
  logic [reg_addr_width_p-1:0] fdiv_id_i;
  logic                        fdiv_yumi_o;
  logic                        stall_all_i;
  logic                        int_sb_clear_o;
  logic [reg_addr_width_p-1:0] int_sb_clear_id_o;
  logic                        float_sb_clear_o;
  logic [reg_addr_width_p-1:0] float_sb_clear_id_o;
  logic [count_width_lp-1:0]   out_count_o;
  logic                        out_full_o;
  logic                        err_o;

  modport master (
    output issue_remote_ld_i, rsp_v_i, rsp_float_i, rsp_id_i,
           idiv_v_i, idiv_id_i, fdiv_v_i, fdiv_id_i, stall_all_i,
    input  rsp_ready_o, idiv_yumi_o, fdiv_yumi_o,
           int_sb_clear_o, int_sb_clear_id_o, float_sb_clear_o, float_sb_clear_id_o,
           out_count_o, out_full_o, err_o
  );

  modport slave (
    input  issue_remote_ld_i, rsp_v_i, rsp_float_i, rsp_id_i,
           idiv_v_i, idiv_id_i, fdiv_v_i, fdiv_id_i, stall_all_i,
    output rsp_ready_o, idiv_yumi_o, fdiv_yumi_o,
           int_sb_clear_o, int_sb_clear_id_o, float_sb_clear_o, float_sb_clear_id_o,
           out_count_o, out_full_o, err_o
  );

endinterface

// File: rtl/bsg_fifo_1r1w_small.sv
// rtl/bsg_fifo_1r1w_small.sv - small ready/valid-in, valid/yumi-out FIFO (active-low sync reset)
module bsg_fifo_1r1w_small #(
  parameter int width_p = 6,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_w_lp = $clog2(els_p);
  localparam logic [ptr_w_lp:0] els_lp = (ptr_w_lp+1)'(els_p);

  logic [width_p-1:0]  mem [els_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
  logic [ptr_w_lp:0]   count;
  logic                enq, deq;

  assign ready_o = (count != els_lp);
  assign v_o     = (count != '0);
  assign data_o  = mem[rd_ptr];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + ptr_w_lp'(1);
      if (deq) rd_ptr <= rd_ptr + ptr_w_lp'(1);
      case ({enq, deq})
        2'b10:   count <= count + (ptr_w_lp+1)'(1);
        2'b01:   count <= count - (ptr_w_lp+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vanilla_sb_clear_arbiter.sv
// rtl/vanilla_sb_clear_arbiter.sv - int/float scoreboard clear arbiter; optional VANILLA_SB_CLEAR_DUP_CHECK_EN
module vanilla_sb_clear_arbiter
  import vanilla_sb_clear_pkg::*;
#(
  parameter int reg_addr_width_p = sb_clear_reg_addr_width_gp,
  parameter int fifo_els_p       = 4,
  parameter int max_out_p        = 16,
  parameter int count_width_lp   = $clog2(max_out_p + 1)
) (
  input logic clk_i,
  input logic reset_i,
  vanilla_sb_clear_arbiter_if.slave bus
);
  localparam logic [count_width_lp-1:0] max_out_lp = count_width_lp'(max_out_p);

  sb_clear_rsp_s push_data, head;
  logic          fifo_ready, head_v, enq, pop;
  logic          int_head, float_head;
  logic          int_fifo_win, int_unit_win, float_fifo_win, float_unit_win;
  logic          int_contend, float_contend;
  logic          rr_int, rr_float;
  logic          cnt_err, dup_err;
  logic [count_width_lp-1:0] count;

  assign push_data = '{is_float: bus.rsp_float_i, id: bus.rsp_id_i};
  assign enq       = bus.rsp_v_i & fifo_ready;

  bsg_fifo_1r1w_small #(.width_p($bits(sb_clear_rsp_s)), .els_p(fifo_els_p)) rsp_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (bus.rsp_v_i),
    .ready_o (fifo_ready),
    .data_i  (push_data),
    .v_o     (head_v),
    .data_o  (head),
    .yumi_i  (pop)
  );

  // Per file: head vs. functional unit; the rr flag only matters when both are valid.
  always_comb begin
    int_head       = head_v & ~head.is_float;
    float_head     = head_v &  head.is_float;
    int_contend    = ~bus.stall_all_i & int_head & bus.idiv_v_i;
    float_contend  = ~bus.stall_all_i & float_head & bus.fdiv_v_i;
    int_fifo_win   = ~bus.stall_all_i & int_head
                   & (~bus.idiv_v_i | (rr_int == sb_clear_src_fifo_gp));
    int_unit_win   = ~bus.stall_all_i & bus.idiv_v_i
                   & (~int_head | (rr_int == sb_clear_src_unit_gp));
    float_fifo_win = ~bus.stall_all_i & float_head
                   & (~bus.fdiv_v_i | (rr_float == sb_clear_src_fifo_gp));
    float_unit_win = ~bus.stall_all_i & bus.fdiv_v_i
                   & (~float_head | (rr_float == sb_clear_src_unit_gp));
    pop            = int_fifo_win | float_fifo_win;
    cnt_err        = (bus.issue_remote_ld_i & ~pop & (count == max_out_lp))
                   | (pop & ~bus.issue_remote_ld_i & (count == '0));
  end

  assign bus.rsp_ready_o = fifo_ready;
  assign bus.idiv_yumi_o = int_unit_win;
  assign bus.fdiv_yumi_o = float_unit_win;
  assign bus.out_count_o = count;
  assign bus.out_full_o  = (count == max_out_lp);

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rr_int                  <= sb_clear_src_fifo_gp;
      rr_float                <= sb_clear_src_fifo_gp;
      bus.int_sb_clear_o      <= 1'b0;
      bus.int_sb_clear_id_o   <= '0;
      bus.float_sb_clear_o    <= 1'b0;
      bus.float_sb_clear_id_o <= '0;
      count                   <= '0;
      bus.err_o               <= 1'b0;
    end else begin
      bus.int_sb_clear_o   <= int_fifo_win | int_unit_win;
      bus.float_sb_clear_o <= float_fifo_win | float_unit_win;
      if (int_fifo_win)        bus.int_sb_clear_id_o   <= head.id;
      else if (int_unit_win)   bus.int_sb_clear_id_o   <= bus.idiv_id_i;
      if (float_fifo_win)      bus.float_sb_clear_id_o <= head.id;
      else if (float_unit_win) bus.float_sb_clear_id_o <= bus.fdiv_id_i;
      if (int_contend)   rr_int   <= int_fifo_win   ? sb_clear_src_unit_gp : sb_clear_src_fifo_gp;
      if (float_contend) rr_float <= float_fifo_win ? sb_clear_src_unit_gp : sb_clear_src_fifo_gp;
      if (!cnt_err) begin
        case ({bus.issue_remote_ld_i, pop})
          2'b10:   count <= count + count_width_lp'(1);
          2'b01:   count <= count - count_width_lp'(1);
          default: count <= count;
        endcase
      end
      bus.err_o <= bus.err_o | cnt_err | dup_err;
    end
  end

`ifdef VANILLA_SB_CLEAR_DUP_CHECK_EN
  localparam int ptr_w_lp = $clog2(fifo_els_p);

  // Shadow of FIFO occupancy so every in-flight entry can be compared in parallel.
  logic [fifo_els_p-1:0] sh_v;
  sb_clear_rsp_s         sh_d [fifo_els_p];
  logic [ptr_w_lp-1:0]   sh_wr, sh_rd;

  always_ff @(posedge clk_i) begin
    if (enq) sh_d[sh_wr] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      sh_v  <= '0;
      sh_wr <= '0;
      sh_rd <= '0;
    end else begin
      if (enq) begin
        sh_v[sh_wr] <= 1'b1;
        sh_wr       <= sh_wr + ptr_w_lp'(1);
      end
      if (pop) begin
        sh_v[sh_rd] <= 1'b0;
        sh_rd       <= sh_rd + ptr_w_lp'(1);
      end
    end
  end

  always_comb begin
    dup_err = 1'b0;
    for (int i = 0; i < fifo_els_p; i++) begin
      if (sh_v[i]) begin
        if (enq && sh_d[i] == push_data) dup_err = 1'b1;
        if (bus.idiv_v_i && !sh_d[i].is_float && sh_d[i].id == bus.idiv_id_i) dup_err = 1'b1;
        if (bus.fdiv_v_i &&  sh_d[i].is_float && sh_d[i].id == bus.fdiv_id_i) dup_err = 1'b1;
      end
    end
  end
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_vanilla_sb_clear_arbiter.sv
// tb/tb_vanilla_sb_clear_arbiter.sv - scoreboard bench for vanilla_sb_clear_arbiter
module tb_vanilla_sb_clear_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [4:0] exp_int[$];
  logic [4:0] exp_float[$];
  logic [4:0] got;
  logic exp_yumi [4];

  always #5 clk = ~clk;

  vanilla_sb_clear_arbiter_if #(.reg_addr_width_p(5), .count_width_lp(5)) bus ();

  vanilla_sb_clear_arbiter #(
    .reg_addr_width_p(5), .fifo_els_p(4), .max_out_p(16), .count_width_lp(5)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Clear-stream monitor: every strobe must match the oldest expected id for its file.
  always @(negedge clk) begin
    if (bus.int_sb_clear_o === 1'b1) begin
      if (exp_int.size() == 0) chk("int_clear_unexpected", 1, 0);
      else begin
        got = exp_int.pop_front();
        chk("int_clear_id", bus.int_sb_clear_id_o, got);
      end
    end
    if (bus.float_sb_clear_o === 1'b1) begin
      if (exp_float.size() == 0) chk("float_clear_unexpected", 1, 0);
      else begin
        got = exp_float.pop_front();
        chk("float_clear_id", bus.float_sb_clear_id_o, got);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.issue_remote_ld_i = 0; bus.rsp_v_i = 0; bus.rsp_float_i = 0; bus.rsp_id_i = 0;
    bus.idiv_v_i = 0; bus.idiv_id_i = 0; bus.fdiv_v_i = 0; bus.fdiv_id_i = 0;
    bus.stall_all_i = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    rst = 1;
  endtask

  task automatic issue_n(input int n);
    bus.issue_remote_ld_i = 1;
    repeat (n) tick();
    bus.issue_remote_ld_i = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_count", bus.out_count_o, 0);
    chk("rst_full", bus.out_full_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_int_clear", bus.int_sb_clear_o, 0);
    chk("rst_int_id", bus.int_sb_clear_id_o, 0);
    chk("rst_float_clear", bus.float_sb_clear_o, 0);
    chk("rst_float_id", bus.float_sb_clear_id_o, 0);
    chk("rst_ready", bus.rsp_ready_o, 1);

    // single int response, 2-cycle latency
    issue_n(1);
    chk("t1_count_up", bus.out_count_o, 1);
    bus.rsp_v_i = 1; bus.rsp_float_i = 0; bus.rsp_id_i = 7;
    exp_int.push_back(7);
    tick();
    bus.rsp_v_i = 0;
    chk("t1_no_clear_yet", bus.int_sb_clear_o, 0);
    tick();
    chk("t1_clear", bus.int_sb_clear_o, 1);
    chk("t1_clear_id", bus.int_sb_clear_id_o, 7);
    chk("t1_count_down", bus.out_count_o, 0);
    tick();
    chk("t1_clear_drop", bus.int_sb_clear_o, 0);
    chk("t1_id_hold", bus.int_sb_clear_id_o, 7);
    tick();

    // idiv vs FIFO contention alternates, FIFO first
    do_reset();
    issue_n(2);
    bus.stall_all_i = 1;
    bus.rsp_v_i = 1; bus.rsp_float_i = 0; bus.rsp_id_i = 9;
    tick(); tick();
    bus.rsp_v_i = 0;
    bus.stall_all_i = 0;
    bus.idiv_v_i = 1; bus.idiv_id_i = 3;
    exp_int.push_back(9); exp_int.push_back(3); exp_int.push_back(9); exp_int.push_back(3);
    exp_yumi[0] = 0; exp_yumi[1] = 1; exp_yumi[2] = 0; exp_yumi[3] = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t2_yumi%0d", k), bus.idiv_yumi_o, exp_yumi[k]);
      tick();
    end
    bus.idiv_v_i = 0;
    tick(); tick();
    chk("t2_count", bus.out_count_o, 0);
    chk("t2_q_drained", exp_int.size(), 0);

    // float head + idiv in same cycle clear both files
    do_reset();
    issue_n(1);
    bus.rsp_v_i = 1; bus.rsp_float_i = 1; bus.rsp_id_i = 2;
    tick();
    bus.rsp_v_i = 0; bus.rsp_float_i = 0;
    bus.idiv_v_i = 1; bus.idiv_id_i = 5;
    exp_int.push_back(5); exp_float.push_back(2);
    tick();
    bus.idiv_v_i = 0;
    chk("t3_int_clear", bus.int_sb_clear_o, 1);
    chk("t3_int_id", bus.int_sb_clear_id_o, 5);
    chk("t3_float_clear", bus.float_sb_clear_o, 1);
    chk("t3_float_id", bus.float_sb_clear_id_o, 2);
    tick(); tick();

    // stall while filling, then in-order drain
    do_reset();
    bus.stall_all_i = 1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4_ready_pre%0d", i), bus.rsp_ready_o, 1);
      bus.issue_remote_ld_i = 1;
      bus.rsp_v_i = 1; bus.rsp_float_i = 0; bus.rsp_id_i = 5'(10 + i);
      exp_int.push_back(5'(10 + i));
      tick();
    end
    bus.rsp_v_i = 0; bus.issue_remote_ld_i = 0;
    chk("t4_ready_full", bus.rsp_ready_o, 0);
    chk("t4_count", bus.out_count_o, 4);
    tick();
    chk("t4_stalled_no_clear", bus.int_sb_clear_o, 0);
    bus.stall_all_i = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4_drain_clear%0d", i), bus.int_sb_clear_o, 1);
      chk($sformatf("t4_drain_id%0d", i), bus.int_sb_clear_id_o, 10 + i);
    end
    chk("t4_ready_back", bus.rsp_ready_o, 1);
    chk("t4_count_zero", bus.out_count_o, 0);
    chk("t4_err_clean", bus.err_o, 0);
    tick(); tick();

    // outstanding counter saturation and sticky error
    do_reset();
    issue_n(16);
    chk("t5_count16", bus.out_count_o, 16);
    chk("t5_full", bus.out_full_o, 1);
    chk("t5_err_before", bus.err_o, 0);
    issue_n(1);
    chk("t5_count_hold", bus.out_count_o, 16);
    chk("t5_err_set", bus.err_o, 1);
    tick(); tick();
    chk("t5_err_sticky", bus.err_o, 1);
    do_reset();
    chk("t5_err_reset", bus.err_o, 0);
    chk("t5_count_reset", bus.out_count_o, 0);

    // duplicate float id in flight
    issue_n(2);
    bus.stall_all_i = 1;
    bus.rsp_v_i = 1; bus.rsp_float_i = 1; bus.rsp_id_i = 4;
    exp_float.push_back(4); exp_float.push_back(4);
    tick(); tick();
    bus.rsp_v_i = 0; bus.rsp_float_i = 0;
`ifdef VANILLA_SB_CLEAR_DUP_CHECK_EN
    chk("t6_dup_err", bus.err_o, 1);
`else
    chk("t6_dup_err", bus.err_o, 0);
`endif
    bus.stall_all_i = 0;
    tick(); tick(); tick(); tick();
    chk("t6_count", bus.out_count_o, 0);

    chk("end_int_q_empty", exp_int.size(), 0);
    chk("end_float_q_empty", exp_float.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
